// File: rtl/chunked_ripple_adder.sv
// chunked_ripple_adder: multi-cycle adder that sums CHUNK bits per clock through a ripple
// stage, registering the carry between slices. Define CHUNKED_ADDER_OVF_EN to add the ovf port.
module chunked_ripple_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum_reg;
  logic [WIDTH-1:0] sum_next;
  logic             carry;
  logic [CHUNK:0]   slice_sum;
  logic             accept;
  logic             last;

  assign accept = (state != RUN) && start;
  assign last   = (state == RUN) && (k == K_LAST);
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  assign slice_sum = {1'b0, op_a[k*CHUNK +: CHUNK]}
                   + {1'b0, op_b[k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, carry};

  // The final slice is merged here so s can be loaded whole on the last RUN edge.
  always_comb begin
    sum_next = sum_reg;
    sum_next[k*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: state_next = start ? RUN : IDLE;
      RUN:        state_next = (k == K_LAST) ? DONE : RUN;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      carry   <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      sum_reg <= '0;
      s       <= '0;
      cout    <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
      ovf     <= 1'b0;
`endif
    end else if (accept) begin
      op_a    <= a;
      op_b    <= b;
      carry   <= c0;
      sum_reg <= '0;
      k       <= '0;
    end else if (state == RUN) begin
      sum_reg <= sum_next;
      carry   <= slice_sum[CHUNK];
      k       <= k + KW'(1);
      if (last) begin
        k    <= '0;
        s    <= sum_next;
        cout <= slice_sum[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
        // Carry into the MSB is recovered from the MSB's own sum bit.
        ovf  <= (op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ sum_next[WIDTH-1]) ^ slice_sum[CHUNK];
`endif
      end
    end
  end

endmodule

// File: tb/tb_chunked_ripple_adder.sv
// tb_chunked_ripple_adder: scoreboard bench driving three adder configurations
// (8/2, 2/1 and 4/4) with directed and random operands against an arithmetic model.
module tb_chunked_ripple_adder;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [8:0] sum;
    logic       ovf;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  exp_t q4[$];

  logic       start8, c08, busy8, done8, cout8;
  logic [7:0] a8, b8, s8;
  logic       start2, c02, busy2, done2, cout2;
  logic [1:0] a2, b2, s2;
  logic       start4, c04, busy4, done4, cout4;
  logic [3:0] a4, b4, s4;
`ifdef CHUNKED_ADDER_OVF_EN
  logic       ovf8, ovf2, ovf4;
`endif

  chunked_ripple_adder #(.WIDTH(8), .CHUNK(2)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .c0(c08),
    .busy(busy8), .done(done8), .s(s8), .cout(cout8)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf8)
`endif
  );

  chunked_ripple_adder #(.WIDTH(2), .CHUNK(1)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .a(a2), .b(b2), .c0(c02),
    .busy(busy2), .done(done2), .s(s2), .cout(cout2)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf2)
`endif
  );

  chunked_ripple_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .c0(c04),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4)
`ifdef CHUNKED_ADDER_OVF_EN
    , .ovf(ovf4)
`endif
  );

  // Reference: plain integer sum, and signed overflow as "true signed sum out of range".
  function automatic exp_t model(input int w, input longint ua, input longint ub,
                                 input longint c, input int done_cyc);
    exp_t   e;
    longint half, sa, sb, ss;
    half  = longint'(1) << (w - 1);
    e.sum = 9'(ua + ub + c);
    sa    = (ua >= half) ? ua - 2 * half : ua;
    sb    = (ub >= half) ? ub - 2 * half : ub;
    ss    = sa + sb + c;
    e.ovf = (ss >= half) || (ss < -half);
    e.cyc = done_cyc;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpectedDone(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: done with no outstanding request (cycle %0d)", name, cyc);
  endtask

  // Monitors: pop the oldest expectation whenever a DUT reports done.
  always @(negedge clk) begin
    exp_t e;
    if (done8 === 1'b1) begin
      if (q8.size() == 0) unexpectedDone("done8");
      else begin
        e = q8.pop_front();
        checkOutput("sum8", {23'd0, cout8, s8}, {23'd0, e.sum});
        checkOutput("done8_cycle", cyc, e.cyc);
        checkOutput("busy8_at_done", {31'd0, busy8}, 32'd0);
`ifdef CHUNKED_ADDER_OVF_EN
        checkOutput("ovf8", {31'd0, ovf8}, {31'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) unexpectedDone("done2");
      else begin
        e = q2.pop_front();
        checkOutput("sum2", {29'd0, cout2, s2}, {23'd0, e.sum});
        checkOutput("done2_cycle", cyc, e.cyc);
`ifdef CHUNKED_ADDER_OVF_EN
        checkOutput("ovf2", {31'd0, ovf2}, {31'd0, e.ovf});
`endif
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4 === 1'b1) begin
      if (q4.size() == 0) unexpectedDone("done4");
      else begin
        e = q4.pop_front();
        checkOutput("sum4", {27'd0, cout4, s4}, {23'd0, e.sum});
        checkOutput("done4_cycle", cyc, e.cyc);
`ifdef CHUNKED_ADDER_OVF_EN
        checkOutput("ovf4", {31'd0, ovf4}, {31'd0, e.ovf});
`endif
      end
    end
  end

  function automatic logic doneOf(input int d);
    case (d)
      2:       return done2;
      4:       return done4;
      default: return done8;
    endcase
  endfunction

  function automatic logic busyOf(input int d);
    case (d)
      2:       return busy2;
      4:       return busy4;
      default: return busy8;
    endcase
  endfunction

  // Called at a negedge where the selected DUT can accept; returns one negedge later.
  task automatic applyStimulus(input int d, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input bit track);
    case (d)
      2: begin
        a2 = a[1:0]; b2 = b[1:0]; c02 = c; start2 = 1'b1;
        if (track) q2.push_back(model(2, longint'(a[1:0]), longint'(b[1:0]), longint'(c), cyc + 1 + 2));
      end
      4: begin
        a4 = a[3:0]; b4 = b[3:0]; c04 = c; start4 = 1'b1;
        if (track) q4.push_back(model(4, longint'(a[3:0]), longint'(b[3:0]), longint'(c), cyc + 1 + 1));
      end
      default: begin
        a8 = a; b8 = b; c08 = c; start8 = 1'b1;
        if (track) q8.push_back(model(8, longint'(a), longint'(b), longint'(c), cyc + 1 + 4));
      end
    endcase
    @(negedge clk);
    start2 = 1'b0;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  // Waits (bounded) for done, counting busy cycles seen on the way.
  task automatic waitDone(input int d, input int exp_busy);
    int n  = 0;
    int nb = 0;
    while (doneOf(d) !== 1'b1 && n < 64) begin
      if (busyOf(d) === 1'b1) nb++;
      @(negedge clk);
      n++;
    end
    if (doneOf(d) !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout dut%0d: no done within %0d cycles", d, n);
    end else begin
      checkOutput("busy_cycles", nb, exp_busy);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nd;
    reset = 1'b1;
    {start8, a8, b8, c08} = '0;
    {start2, a2, b2, c02} = '0;
    {start4, a4, b4, c04} = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy8", {31'd0, busy8}, 32'd0);
    checkOutput("reset_done8", {31'd0, done8}, 32'd0);
    checkOutput("reset_sum8", {23'd0, cout8, s8}, 32'd0);
    checkOutput("reset_busy2", {31'd0, busy2}, 32'd0);
    checkOutput("reset_sum4", {27'd0, cout4, s4}, 32'd0);
`ifdef CHUNKED_ADDER_OVF_EN
    checkOutput("reset_ovf8", {31'd0, ovf8}, 32'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] exhaustive sweep WIDTH=2 CHUNK=1");
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      applyStimulus(2, {6'd0, v[1:0]}, {6'd0, v[3:2]}, v[4], 1'b1);
      waitDone(2, 2);
    end

    $display("[TB] single-cycle corner WIDTH=CHUNK=4");
    applyStimulus(4, 8'h09, 8'h08, 1'b1, 1'b1);
    waitDone(4, 1);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(4, 8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 1'($urandom), 1'b1);
      waitDone(4, 1);
    end

    $display("[TB] directed WIDTH=8 CHUNK=2");
    applyStimulus(8, 8'hFF, 8'h01, 1'b0, 1'b1);
    waitDone(8, 4);
    @(negedge clk);
    applyStimulus(8, 8'h7F, 8'h01, 1'b0, 1'b1);
    waitDone(8, 4);
    applyStimulus(8, 8'h80, 8'h80, 1'b0, 1'b1);
    waitDone(8, 4);

    // A start during RUN (with new operands on the pins) must be ignored.
    @(negedge clk);
    applyStimulus(8, 8'h33, 8'h4C, 1'b1, 1'b1);
    a8 = 8'h10; b8 = 8'h22; c08 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    waitDone(8, 3);

    // Start in the DONE cycle is accepted; the monitor checks the 5-cycle spacing.
    applyStimulus(8, 8'hA5, 8'h5A, 1'b1, 1'b1);
    waitDone(8, 4);

    $display("[TB] random WIDTH=8 CHUNK=2");
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      applyStimulus(8, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
      waitDone(8, 4);
    end

    $display("[TB] reset mid-operation");
    @(negedge clk);
    applyStimulus(8, 8'hC3, 8'h7E, 1'b1, 1'b1);
    void'(q8.pop_back());
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_busy8", {31'd0, busy8}, 32'd0);
    checkOutput("abort_sum8", {23'd0, cout8, s8}, 32'd0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      if (done8 === 1'b1) nd++;
      @(negedge clk);
    end
    checkOutput("abort_no_done", nd, 0);

    // Reset and start together: reset must win.
    reset = 1'b1;
    a8 = 8'h01; b8 = 8'h01; start8 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start8 = 1'b0;
    checkOutput("reset_beats_start", {31'd0, busy8}, 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("q8_drained", q8.size(), 0);
    checkOutput("q2_drained", q2.size(), 0);
    checkOutput("q4_drained", q4.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
